// File: rtl/deserializer.sv
// Serial-to-parallel word assembler with per-word bit order, a one-word output
// holding register, sticky overrun flag and abort.
module deserializer #(
   parameter int W = 8
) (
   input  logic         c,
   input  logic         nrst,
   input  logic         si,
   input  logic         sv,
   input  logic         sof,
   input  logic         ab,
   input  logic         dir,
   output logic [W-1:0] q,
   output logic         qv,
   input  logic         qr,
   output logic         ovf,
   input  logic         clr,
   output logic         busy
);

   localparam int CW = (W > 2) ? $clog2(W) : 1;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W-1:0]   sreg_q, sreg_d;
   logic           ldir_q, ldir_d;
   logic [W-1:0]   q_q, q_d;
   logic           qv_q, qv_d;
   logic           ovf_q, ovf_d;
   logic           busy_q, busy_d;

   logic [W-1:0]   first_s;
   logic [W-1:0]   shifted_s;
   logic           start_s;
   logic           done_s;
   logic           overrun_s;

   // Next-state, shift register and output holding-register logic
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sreg_d    = sreg_q;
      ldir_d    = ldir_q;
      q_d       = q_q;
      qv_d      = qv_q;
      ovf_d     = ovf_q;
      done_s    = 1'b0;
      overrun_s = 1'b0;

      // First bit of a word lands at the end it will be shifted away from
      first_s   = dir ? {si, {(W-1){1'b0}}} : {{(W-1){1'b0}}, si};
      shifted_s = ldir_q ? {si, sreg_q[W-1:1]} : {sreg_q[W-2:0], si};
      start_s   = sof || ((state_q == SHIFT) && (cnt_q == {CW{1'b0}}));

      if (ab) begin
         state_d = IDLE;
         cnt_d   = {CW{1'b0}};
      end else if (sv) begin
         if (start_s) begin
            sreg_d  = first_s;
            cnt_d   = {{(CW-1){1'b0}}, 1'b1};
            ldir_d  = dir;
            state_d = SHIFT;
         end else if (state_q == SHIFT) begin
            sreg_d = shifted_s;
            if (cnt_q == CW'(W - 1)) begin
               cnt_d  = {CW{1'b0}};
               done_s = 1'b1;
            end else begin
               cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            end
         end else begin
            state_d = IDLE;
         end
      end else begin
         state_d = state_q;
      end

      if (done_s) begin
         if (!qv_q || qr) begin
            q_d  = shifted_s;
            qv_d = 1'b1;
         end else begin
            overrun_s = 1'b1;
         end
      end else if (qv_q && qr) begin
         qv_d = 1'b0;
      end else begin
         qv_d = qv_q;
      end

      // A new overrun outranks a clear on the same edge
      if (overrun_s) begin
         ovf_d = 1'b1;
      end else if (clr) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end

      busy_d = (state_d == SHIFT);
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge c) begin
      if (!nrst) begin
         state_q <= IDLE;
         cnt_q   <= {CW{1'b0}};
         sreg_q  <= {W{1'b0}};
         ldir_q  <= 1'b0;
         q_q     <= {W{1'b0}};
         qv_q    <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sreg_q  <= sreg_d;
         ldir_q  <= ldir_d;
         q_q     <= q_d;
         qv_q    <= qv_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
      end
   end

   assign q    = q_q;
   assign qv   = qv_q;
   assign ovf  = ovf_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_deserializer.sv
// Directed test of the deserializer: bit order, overrun, resync on sof,
// abort and mid-word reset, checked with immediate assertions.
module tb_deserializer;

   logic       c = 1'b0;
   logic       nrst, si, sv, sof, ab, dir, qr, clr;
   logic [7:0] q;
   logic       qv, ovf, busy;
   int         total = 0;
   int         bad   = 0;

   deserializer #(.W(8)) dut (
      .c(c), .nrst(nrst), .si(si), .sv(sv), .sof(sof), .ab(ab), .dir(dir),
      .q(q), .qv(qv), .qr(qr), .ovf(ovf), .clr(clr), .busy(busy)
   );

   always #5 c = ~c;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Sends 8 bits in order v[7]..v[0]; dir is inverted at bit index tog
   task automatic send(input logic [7:0] v, input logic first_sof, input logic d, input int tog);
      for (int i = 0; i < 8; i++) begin
         @(negedge c);
         if (i > 0) chk("busy_mid_word", {7'd0, busy}, 8'd1);
         si  = v[7-i];
         sv  = 1'b1;
         sof = (i == 0) ? first_sof : 1'b0;
         if (i == 0) dir = d;
         if (i == tog) dir = ~d;
      end
      @(negedge c);
      sv  = 1'b0;
      sof = 1'b0;
   endtask

   task automatic drain();
      qr = 1'b1;
      @(negedge c);
      chk("qv_drained", {7'd0, qv}, 8'd0);
   endtask

   initial begin
      nrst = 1'b0; si = 1'b0; sv = 1'b0; sof = 1'b0; ab = 1'b0;
      dir = 1'b0; qr = 1'b1; clr = 1'b0;
      repeat (2) @(negedge c);
      chk("rst_q", q, 8'h00);
      chk("rst_qv", {7'd0, qv}, 8'd0);
      chk("rst_ovf", {7'd0, ovf}, 8'd0);
      chk("rst_busy", {7'd0, busy}, 8'd0);
      nrst = 1'b1;

      // sv without sof in IDLE is ignored
      @(negedge c); si = 1'b1; sv = 1'b1;
      @(negedge c); sv = 1'b0;
      chk("idle_ignore_busy", {7'd0, busy}, 8'd0);

      // MSB first, 0xA5
      send(8'b10100101, 1'b1, 1'b0, -1);
      chk("msb_q", q, 8'hA5);
      chk("msb_qv", {7'd0, qv}, 8'd1);
      chk("msb_busy_after", {7'd0, busy}, 8'd1);
      drain();

      // LSB first, bits 1,0,0,0,1,1,0,1 -> 0xB1
      send(8'b10001101, 1'b1, 1'b1, -1);
      chk("lsb_q", q, 8'hB1);
      chk("lsb_qv", {7'd0, qv}, 8'd1);
      drain();

      // Same word, dir toggled after bit 3
      send(8'b10001101, 1'b1, 1'b1, 3);
      chk("lsb_toggle_q", q, 8'hB1);
      drain();

      // Overrun: 0x12 then 0x34 back-to-back with qr=0
      qr = 1'b0;
      send(8'h12, 1'b1, 1'b0, -1);
      chk("ovr_first_q", q, 8'h12);
      chk("ovr_first_ovf", {7'd0, ovf}, 8'd0);
      send(8'h34, 1'b0, 1'b0, -1);
      chk("ovr_hold_q", q, 8'h12);
      chk("ovr_hold_qv", {7'd0, qv}, 8'd1);
      chk("ovr_ovf", {7'd0, ovf}, 8'd1);
      clr = 1'b1; qr = 1'b1;
      @(negedge c);
      clr = 1'b0;
      chk("clr_ovf", {7'd0, ovf}, 8'd0);
      chk("clr_qv", {7'd0, qv}, 8'd0);

      // Partial word of 5 bits, then resync with sof to 0x0F
      for (int i = 0; i < 5; i++) begin
         @(negedge c);
         si = 1'b1; sv = 1'b1; sof = (i == 0);
      end
      send(8'h0F, 1'b1, 1'b0, -1);
      chk("resync_q", q, 8'h0F);
      chk("resync_qv", {7'd0, qv}, 8'd1);
      drain();

      // Abort after 4 bits, with sv and sof also high on the abort edge
      for (int i = 0; i < 4; i++) begin
         @(negedge c);
         si = 1'b1; sv = 1'b1; sof = (i == 0);
      end
      @(negedge c);
      ab = 1'b1; sv = 1'b1; sof = 1'b1;
      @(negedge c);
      ab = 1'b0; sv = 1'b0; sof = 1'b0;
      chk("abort_busy", {7'd0, busy}, 8'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge c);
         si = 1'b0; sv = 1'b1;
      end
      @(negedge c);
      sv = 1'b0;
      chk("abort_after_busy", {7'd0, busy}, 8'd0);
      chk("abort_after_qv", {7'd0, qv}, 8'd0);
      chk("abort_q_kept", q, 8'h0F);

      // Reset mid-word while a word is held
      qr = 1'b0;
      send(8'h5A, 1'b1, 1'b0, -1);
      chk("pre_rst_q", q, 8'h5A);
      for (int i = 0; i < 6; i++) begin
         @(negedge c);
         si = 1'b1; sv = 1'b1;
      end
      @(negedge c);
      sv = 1'b0; nrst = 1'b0;
      chk("pre_rst_qv", {7'd0, qv}, 8'd1);
      chk("pre_rst_busy", {7'd0, busy}, 8'd1);
      @(negedge c);
      nrst = 1'b1;
      chk("mid_rst_q", q, 8'h00);
      chk("mid_rst_qv", {7'd0, qv}, 8'd0);
      chk("mid_rst_ovf", {7'd0, ovf}, 8'd0);
      chk("mid_rst_busy", {7'd0, busy}, 8'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge c);
         si = 1'b1; sv = 1'b1;
      end
      @(negedge c);
      sv = 1'b0;
      chk("post_rst_nosof_busy", {7'd0, busy}, 8'd0);
      qr = 1'b1;
      send(8'hC3, 1'b1, 1'b0, -1);
      chk("post_rst_q", q, 8'hC3);
      chk("post_rst_qv", {7'd0, qv}, 8'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
